// File: rtl/tsup_pkg.sv
// Shared types and constants for the test supervisor.
//   tsup_state_t : supervisor FSM states
//   CAUSE_*      : fail_cause encodings
//   tsup_max     : helper for sizing the shared RESET/DRAIN counter
package tsup_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } tsup_state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TRAP    = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic int tsup_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tsup_prio_enc.sv
// Lowest-index-first priority encoder for the trap sources.
//   req_i : N request bits
//   idx_o : index of the lowest set bit (0 when none set)
//   vld_o : any request bit set
module tsup_prio_enc #(
  parameter int N = 1
) (
  input  logic [N-1:0] req_i,
  output logic [3:0]   idx_o,
  output logic         vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = |req_i;
    // Scan downwards so the lowest set index is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/test_supervisor.sv
// Run supervisor: sequences the system reset, counts run cycles, watches
// trap sources, a pass flag and an optional watchdog kick, and latches a
// sticky verdict before raising finish.
//   clk              : system clock
//   power_on_reset_n : asynchronous active-low reset
//   trap[N_TRAP]     : per-source trap flags
//   done             : pass flag from the system under test
//   kick             : watchdog restart (only when KICK_EN=1)
//   sys_reset        : active-high reset to the system
//   running          : high while in RUN
//   pass / fail      : sticky verdict
//   fail_cause       : 00 none, 01 trap, 10 timeout
//   trap_id          : lowest trap index that fired
//   finish           : level, high once halted
//   cycle_count      : saturating run-cycle count
module test_supervisor
  import tsup_pkg::*;
#(
  parameter int RESET_CYCLES   = 5,
  parameter int TIMEOUT_CYCLES = 2045,
  parameter int N_TRAP         = 1,
  parameter int DRAIN_CYCLES   = 5,
  parameter bit KICK_EN        = 1'b0,
  parameter int CW             = 16
) (
  input  logic              clk,
  input  logic              power_on_reset_n,
  input  logic [N_TRAP-1:0] trap,
  input  logic              done,
  input  logic              kick,
  output logic              sys_reset,
  output logic              running,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_cause,
  output logic [3:0]        trap_id,
  output logic              finish,
  output logic [CW-1:0]     cycle_count
);

  localparam int CNT_MAX  = tsup_max(RESET_CYCLES, DRAIN_CYCLES);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int DRN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] RST_END = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRN_END = CNT_W'(DRN_LAST);
  localparam logic [CW-1:0]    TMO_LD  = CW'(TIMEOUT_CYCLES);

  if (N_TRAP < 1 || N_TRAP > 16) begin : g_chk_ntrap
    $error("test_supervisor: N_TRAP must be 1..16");
  end
  if (RESET_CYCLES < 1) begin : g_chk_rst
    $error("test_supervisor: RESET_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("test_supervisor: TIMEOUT_CYCLES must be >= 1");
  end
  if ((longint'(TIMEOUT_CYCLES) >> CW) != 0) begin : g_chk_tmo_w
    $error("test_supervisor: TIMEOUT_CYCLES must fit in CW bits");
  end

  tsup_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // shared by RESET and DRAIN
  logic [CW-1:0]    tmo_q, tmo_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             sys_reset_q, sys_reset_d;
  logic             running_q, running_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [1:0]       cause_q, cause_d;
  logic [3:0]       tid_q, tid_d;
  logic             finish_q, finish_d;
  logic             verdict;

  logic [3:0]       trap_idx;
  logic             trap_vld;

  tsup_prio_enc #(.N(N_TRAP)) u_enc (
    .req_i (trap),
    .idx_o (trap_idx),
    .vld_o (trap_vld)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    cyc_d       = cyc_q;
    sys_reset_d = sys_reset_q;
    running_d   = running_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    cause_d     = cause_q;
    tid_d       = tid_q;
    verdict     = 1'b0;
    // finish follows HALT by one edge so DRAIN_CYCLES=0 still gives one
    // edge between verdict and finish.
    finish_d    = (state_q == HALT);

    unique case (state_q)
      RESET: begin
        if (cnt_q == RST_END) begin
          state_d     = RUN;
          cnt_d       = '0;
          sys_reset_d = 1'b0;
          running_d   = 1'b1;
          tmo_d       = TMO_LD;
          cyc_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (cyc_q != {CW{1'b1}}) cyc_d = cyc_q + CW'(1);
        tmo_d = tmo_q - CW'(1);
        if (trap_vld) begin
          verdict = 1'b1;
          fail_d  = 1'b1;
          cause_d = CAUSE_TRAP;
          tid_d   = trap_idx;
        end else if (done) begin
          verdict = 1'b1;
          pass_d  = 1'b1;
          cause_d = CAUSE_NONE;
        end else if (KICK_EN && kick) begin
          // A kick beats a timeout that would land on this same edge.
          tmo_d = TMO_LD;
        end else if (tmo_q == CW'(1)) begin
          verdict = 1'b1;
          fail_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
        if (verdict) begin
          running_d = 1'b0;
          cnt_d     = '0;
          state_d   = (DRAIN_CYCLES == 0) ? HALT : DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == DRN_END) state_d = HALT;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      HALT: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state_q     <= RESET;
      cnt_q       <= '0;
      tmo_q       <= '0;
      cyc_q       <= '0;
      sys_reset_q <= 1'b1;
      running_q   <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
      tid_q       <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      cyc_q       <= cyc_d;
      sys_reset_q <= sys_reset_d;
      running_q   <= running_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      cause_q     <= cause_d;
      tid_q       <= tid_d;
      finish_q    <= finish_d;
    end
  end

  assign sys_reset   = sys_reset_q;
  assign running     = running_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_cause  = cause_q;
  assign trap_id     = tid_q;
  assign finish      = finish_q;
  assign cycle_count = cyc_q;

endmodule
